id_ex_issue_stage: RTL and testbench

//  ID/EX pipeline register feeding the EX-stage ALU. Decodes opcode/funct into the
//  4-bit ALUCon code and selects operands. Applies EX/MEM and MEM/WB forwarding and

---
 rtl/id_ex_issue_stage.sv | 202 ++++++++++++++++++++
 tb/tb_id_ex_issue_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_issue_stage.sv
// ID/EX issue register: decodes ALUCon, selects and forwards ALU operands, and holds one
// instruction under a valid/ready handshake with flush and stall-time forwarding refresh.
module id_ex_issue_stage #(
    parameter int DW   = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [4:0]      shamt,
    input  logic [15:0]     imm16,
    input  logic [RIDX-1:0] rs_idx,
    input  logic [RIDX-1:0] rt_idx,
    input  logic [RIDX-1:0] rd_idx,
    input  logic [DW-1:0]   rs_data,
    input  logic [DW-1:0]   rt_data,
    input  logic            fwd_m_we,
    input  logic [RIDX-1:0] fwd_m_idx,
    input  logic [DW-1:0]   fwd_m_data,
    input  logic            fwd_w_we,
    input  logic [RIDX-1:0] fwd_w_idx,
    input  logic [DW-1:0]   fwd_w_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      ALUCon,
    output logic [DW-1:0]   DataA,
    output logic [DW-1:0]   DataB,
    output logic [RIDX-1:0] dst_idx,
    output logic            reg_we,
    output logic            trap_en,
    output logic            illegal
);

    typedef struct packed {
        logic       legal;
        logic [3:0] alucon;
        logic       trap;
        logic       imm;
        logic       sext;
        logic       shift;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: begin d.alucon = 4'b0010; d.trap = 1'b1; end
                    6'h21: d.alucon = 4'b0010;
                    6'h22: begin d.alucon = 4'b0110; d.trap = 1'b1; end
                    6'h23: d.alucon = 4'b1001;
                    6'h24: d.alucon = 4'b0000;
                    6'h25: d.alucon = 4'b0001;
                    6'h26: d.alucon = 4'b1010;
                    6'h27: d.alucon = 4'b0100;
                    6'h2A: d.alucon = 4'b0111;
                    6'h00: begin d.alucon = 4'b1000; d.shift = 1'b1; end
                    default: d.legal = 1'b0;
                endcase
            end
            6'h1C: begin
                if (fn == 6'h02) d.alucon = 4'b0011;
                else             d.legal  = 1'b0;
            end
            6'h08: begin d.alucon = 4'b0010; d.imm = 1'b1; d.sext = 1'b1; d.trap = 1'b1; end
            6'h09: begin d.alucon = 4'b0010; d.imm = 1'b1; d.sext = 1'b1; end
            6'h0A: begin d.alucon = 4'b0111; d.imm = 1'b1; d.sext = 1'b1; end
            6'h0C: begin d.alucon = 4'b0000; d.imm = 1'b1; end
            6'h0D: begin d.alucon = 4'b0001; d.imm = 1'b1; end
            6'h0E: begin d.alucon = 4'b1010; d.imm = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        if (!d.legal) d = '0;
        return d;
    endfunction

    // A source index of zero never matches, so non-register operands carry src=0.
    function automatic logic [DW-1:0] fwd_pick(
        input logic [RIDX-1:0] src,
        input logic [DW-1:0]   dflt,
        input logic            m_we,
        input logic [RIDX-1:0] m_idx,
        input logic [DW-1:0]   m_data,
        input logic            w_we,
        input logic [RIDX-1:0] w_idx,
        input logic [DW-1:0]   w_data
    );
        if (src != '0 && m_we && m_idx == src)      return m_data;
        else if (src != '0 && w_we && w_idx == src) return w_data;
        else                                        return dflt;
    endfunction

    logic            out_valid_q, out_valid_d;
    logic [3:0]      alucon_q, alucon_d;
    logic [DW-1:0]   data_a_q, data_a_d;
    logic [DW-1:0]   data_b_q, data_b_d;
    logic [RIDX-1:0] dst_q, dst_d;
    logic            reg_we_q, reg_we_d;
    logic            trap_q, trap_d;
    logic            illegal_q, illegal_d;
    logic [RIDX-1:0] a_src_q, a_src_d;
    logic [RIDX-1:0] b_src_q, b_src_d;

    dec_t            dec;
    logic [RIDX-1:0] cap_a_src, cap_b_src, cap_dst;
    logic [DW-1:0]   cap_a_rf, cap_b_raw;
    logic            capture;

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready;

    always_comb begin
        dec       = decode(opcode, funct);
        cap_a_src = dec.shift ? rt_idx  : rs_idx;
        cap_a_rf  = dec.shift ? rt_data : rs_data;
        cap_b_src = (dec.imm || dec.shift) ? '0 : rt_idx;
        if (dec.shift)                cap_b_raw = {{(DW-5){1'b0}}, shamt};
        else if (dec.imm && dec.sext) cap_b_raw = {{(DW-16){imm16[15]}}, imm16};
        else if (dec.imm)             cap_b_raw = {{(DW-16){1'b0}}, imm16};
        else                          cap_b_raw = rt_data;
        cap_dst = dec.imm ? rt_idx : rd_idx;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        alucon_d    = alucon_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        dst_d       = dst_q;
        reg_we_d    = reg_we_q;
        trap_d      = trap_q;
        illegal_d   = illegal_q;
        a_src_d     = a_src_q;
        b_src_d     = b_src_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            alucon_d    = dec.alucon;
            data_a_d    = fwd_pick(cap_a_src, cap_a_rf, fwd_m_we, fwd_m_idx, fwd_m_data,
                                   fwd_w_we, fwd_w_idx, fwd_w_data);
            data_b_d    = fwd_pick(cap_b_src, cap_b_raw, fwd_m_we, fwd_m_idx, fwd_m_data,
                                   fwd_w_we, fwd_w_idx, fwd_w_data);
            dst_d       = cap_dst;
            reg_we_d    = dec.legal && (cap_dst != '0);
            trap_d      = dec.trap;
            illegal_d   = !dec.legal;
            a_src_d     = cap_a_src;
            b_src_d     = cap_b_src;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            // Stalled: keep register operands in step with results still arriving.
            data_a_d = fwd_pick(a_src_q, data_a_q, fwd_m_we, fwd_m_idx, fwd_m_data,
                                fwd_w_we, fwd_w_idx, fwd_w_data);
            data_b_d = fwd_pick(b_src_q, data_b_q, fwd_m_we, fwd_m_idx, fwd_m_data,
                                fwd_w_we, fwd_w_idx, fwd_w_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alucon_q    <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            dst_q       <= '0;
            reg_we_q    <= 1'b0;
            trap_q      <= 1'b0;
            illegal_q   <= 1'b0;
            a_src_q     <= '0;
            b_src_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alucon_q    <= alucon_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            dst_q       <= dst_d;
            reg_we_q    <= reg_we_d;
            trap_q      <= trap_d;
            illegal_q   <= illegal_d;
            a_src_q     <= a_src_d;
            b_src_q     <= b_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALUCon    = alucon_q;
    assign DataA     = data_a_q;
    assign DataB     = data_b_q;
    assign dst_idx   = dst_q;
    assign reg_we    = reg_we_q;
    assign trap_en   = trap_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Bench for id_ex_issue_stage: directed spec scenarios, then random traffic checked
// against a table-driven reference model of the stage.
module tb_id_ex_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [4:0]  rs_idx, rt_idx, rd_idx;
    logic [31:0] rs_data, rt_data;
    logic        fwd_m_we, fwd_w_we;
    logic [4:0]  fwd_m_idx, fwd_w_idx;
    logic [31:0] fwd_m_data, fwd_w_data;
    logic        flush, out_valid, out_ready;
    logic [3:0]  ALUCon;
    logic [31:0] DataA, DataB;
    logic [4:0]  dst_idx;
    logic        reg_we, trap_en, illegal;

    id_ex_issue_stage #(.DW(32), .RIDX(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .rs_data(rs_data), .rt_data(rt_data),
        .fwd_m_we(fwd_m_we), .fwd_m_idx(fwd_m_idx), .fwd_m_data(fwd_m_data),
        .fwd_w_we(fwd_w_we), .fwd_w_idx(fwd_w_idx), .fwd_w_data(fwd_w_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ALUCon(ALUCon), .DataA(DataA), .DataB(DataB), .dst_idx(dst_idx),
        .reg_we(reg_we), .trap_en(trap_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // kind: 0 reg/reg, 1 shift by shamt, 2 imm sign-extended, 3 imm zero-extended
    typedef struct packed {
        bit [5:0] op;
        bit [5:0] fn;
        bit       any_fn;
        bit [3:0] alu;
        bit [1:0] kind;
        bit       trap;
    } dent_t;

    typedef struct packed {
        bit        v;
        bit [3:0]  alu;
        bit [31:0] a;
        bit [31:0] b;
        bit [4:0]  dst;
        bit        we;
        bit        trap;
        bit        ill;
        bit [4:0]  asrc;
        bit [4:0]  bsrc;
        bit        breg;
    } mst_t;

    dent_t dtab[$];
    mst_t  m;
    int    n_total = 0;
    int    n_pass  = 0;

    task automatic add_ent(input bit [5:0] op, input bit [5:0] fn, input bit any_fn,
                           input bit [3:0] alu, input bit [1:0] kind, input bit trap);
        dent_t e;
        e.op = op; e.fn = fn; e.any_fn = any_fn; e.alu = alu; e.kind = kind; e.trap = trap;
        dtab.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit [31:0] mfwd(input bit [4:0] src, input bit [31:0] dflt);
        if (src != 0 && fwd_m_we && fwd_m_idx == src) return fwd_m_data;
        if (src != 0 && fwd_w_we && fwd_w_idx == src) return fwd_w_data;
        return dflt;
    endfunction

    function automatic mst_t model_capture();
        mst_t  n;
        bit    found = 0;
        dent_t e = '0;
        n = '0;
        foreach (dtab[i])
            if (!found && dtab[i].op == opcode && (dtab[i].any_fn || dtab[i].fn == funct)) begin
                found = 1;
                e = dtab[i];
            end
        n.v    = 1;
        n.ill  = !found;
        n.alu  = found ? e.alu : 4'b0000;
        n.trap = found && e.trap;
        n.dst  = (found && e.kind >= 2) ? rt_idx : rd_idx;
        n.we   = found && n.dst != 0;
        if (found && e.kind == 1) begin
            n.asrc = rt_idx; n.a = mfwd(rt_idx, rt_data);
            n.breg = 0;      n.b = 32'(shamt);
        end else begin
            n.asrc = rs_idx; n.a = mfwd(rs_idx, rs_data);
            if (found && e.kind == 2)      begin n.breg = 0; n.b = 32'(signed'(imm16)); end
            else if (found && e.kind == 3) begin n.breg = 0; n.b = 32'(imm16); end
            else begin n.breg = 1; n.bsrc = rt_idx; n.b = mfwd(rt_idx, rt_data); end
        end
        return n;
    endfunction

    function automatic mst_t model_next(input mst_t cur);
        mst_t n = cur;
        if (flush) n.v = 0;
        else if (in_valid && (!cur.v || out_ready)) n = model_capture();
        else if (cur.v && out_ready) n.v = 0;
        else if (cur.v) begin
            n.a = mfwd(cur.asrc, cur.a);
            if (cur.breg) n.b = mfwd(cur.bsrc, cur.b);
        end
        return n;
    endfunction

    task automatic check_all();
        chk("out_valid", out_valid, m.v);
        chk("in_ready", in_ready, (!m.v || out_ready));
        chk("ALUCon", ALUCon, m.alu);
        chk("DataA", DataA, m.a);
        chk("DataB", DataB, m.b);
        chk("dst_idx", dst_idx, m.dst);
        chk("reg_we", reg_we, m.we);
        chk("trap_en", trap_en, m.trap);
        chk("illegal", illegal, m.ill);
    endtask

    task automatic step();
        mst_t nx;
        nx = model_next(m);
        @(posedge clk);
        #1;
        m = nx;
        check_all();
    endtask

    task automatic set_instr(input bit [5:0] op, input bit [5:0] fn, input bit [4:0] sh,
                             input bit [15:0] imm, input bit [4:0] rs, input bit [4:0] rt,
                             input bit [4:0] rd, input bit [31:0] rsd, input bit [31:0] rtd);
        opcode = op; funct = fn; shamt = sh; imm16 = imm;
        rs_idx = rs; rt_idx = rt; rd_idx = rd; rs_data = rsd; rt_data = rtd;
    endtask

    task automatic clr_fwd();
        fwd_m_we = 0; fwd_m_idx = 0; fwd_m_data = 0;
        fwd_w_we = 0; fwd_w_idx = 0; fwd_w_data = 0;
    endtask

    function automatic bit [5:0] pick_op();
        bit [5:0] ops [13] = '{6'h00, 6'h00, 6'h00, 6'h1C, 6'h08, 6'h09, 6'h0A,
                               6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h02};
        return ops[$urandom_range(0, 12)];
    endfunction

    function automatic bit [5:0] pick_fn();
        bit [5:0] fns [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3F};
        return fns[$urandom_range(0, 13)];
    endfunction

    initial begin
        add_ent(6'h00, 6'h20, 0, 4'b0010, 0, 1);
        add_ent(6'h00, 6'h21, 0, 4'b0010, 0, 0);
        add_ent(6'h00, 6'h22, 0, 4'b0110, 0, 1);
        add_ent(6'h00, 6'h23, 0, 4'b1001, 0, 0);
        add_ent(6'h00, 6'h24, 0, 4'b0000, 0, 0);
        add_ent(6'h00, 6'h25, 0, 4'b0001, 0, 0);
        add_ent(6'h00, 6'h26, 0, 4'b1010, 0, 0);
        add_ent(6'h00, 6'h27, 0, 4'b0100, 0, 0);
        add_ent(6'h00, 6'h2A, 0, 4'b0111, 0, 0);
        add_ent(6'h00, 6'h00, 0, 4'b1000, 1, 0);
        add_ent(6'h1C, 6'h02, 0, 4'b0011, 0, 0);
        add_ent(6'h08, 6'h00, 1, 4'b0010, 2, 1);
        add_ent(6'h09, 6'h00, 1, 4'b0010, 2, 0);
        add_ent(6'h0A, 6'h00, 1, 4'b0111, 2, 0);
        add_ent(6'h0C, 6'h00, 1, 4'b0000, 3, 0);
        add_ent(6'h0D, 6'h00, 1, 4'b0001, 3, 0);
        add_ent(6'h0E, 6'h00, 1, 4'b1010, 3, 0);

        rst_n = 0; in_valid = 0; out_ready = 0; flush = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr_fwd();
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1;

        // add with plain register-file operands
        in_valid = 1; out_ready = 1;
        set_instr(6'h00, 6'h20, 0, 0, 3, 4, 9, 5, 7);
        step();
        chk("t1_alu", ALUCon, 4'b0010);
        chk("t1_a", DataA, 5);
        chk("t1_b", DataB, 7);
        chk("t1_trap", trap_en, 1);
        chk("t1_dst", dst_idx, 9);
        chk("t1_we", reg_we, 1);

        // immediate extension
        set_instr(6'h08, 6'h00, 0, 16'hFFFF, 1, 2, 0, 0, 0);
        step();
        chk("t2_addi_b", DataB, 32'hFFFF_FFFF);
        chk("t2_addi_dst", dst_idx, 2);
        set_instr(6'h0D, 6'h00, 0, 16'hFFFF, 1, 2, 0, 0, 0);
        step();
        chk("t2_ori_b", DataB, 32'h0000_FFFF);
        chk("t2_ori_alu", ALUCon, 4'b0001);

        // forwarding priority and the zero register
        set_instr(6'h00, 6'h21, 0, 0, 8, 9, 10, 32'h11, 32'h22);
        fwd_m_we = 1; fwd_m_idx = 8; fwd_m_data = 32'hAA;
        fwd_w_we = 1; fwd_w_idx = 8; fwd_w_data = 32'hBB;
        step();
        chk("t3_fwd_m_wins", DataA, 32'hAA);
        set_instr(6'h00, 6'h21, 0, 0, 0, 9, 10, 32'h55, 32'h22);
        fwd_m_idx = 0; fwd_m_data = 32'h99; fwd_w_idx = 0;
        step();
        chk("t3_r0_no_fwd", DataA, 32'h55);
        clr_fwd();

        // stall with operand refresh
        set_instr(6'h00, 6'h25, 0, 0, 5, 6, 7, 32'h0F, 32'h10);
        step();
        out_ready = 0;
        set_instr(6'h00, 6'h24, 0, 0, 1, 2, 3, 32'h77, 32'h88);
        step();
        chk("t4_hold1_ready", in_ready, 0);
        fwd_w_we = 1; fwd_w_idx = 6; fwd_w_data = 32'h1234;
        step();
        chk("t4_hold2_b", DataB, 32'h1234);
        chk("t4_hold2_ready", in_ready, 0);
        clr_fwd();
        step();
        chk("t4_hold3_b", DataB, 32'h1234);
        chk("t4_hold3_a", DataA, 32'h0F);
        chk("t4_hold3_alu", ALUCon, 4'b0001);

        // flush beats the offered instruction
        flush = 1;
        step();
        chk("t5_flush_v", out_valid, 0);
        flush = 0; in_valid = 0;
        step();
        chk("t5_flush_nocap", out_valid, 0);

        // asynchronous reset while holding
        in_valid = 1;
        set_instr(6'h00, 6'h22, 0, 0, 3, 4, 9, 32'hDEAD, 32'hBEEF);
        step();
        rst_n = 0;
        #1;
        m = '0;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1;
        check_all();

        // srl is illegal but still issues
        out_ready = 1;
        set_instr(6'h00, 6'h02, 3, 0, 3, 4, 9, 1, 2);
        step();
        chk("t6_ill", illegal, 1);
        chk("t6_ill_we", reg_we, 0);
        chk("t6_ill_v", out_valid, 1);
        chk("t6_ill_alu", ALUCon, 4'b0000);

        // sll takes rt as A and shamt as B
        set_instr(6'h00, 6'h00, 5'd17, 0, 3, 4, 9, 32'h1, 32'hCAFE);
        step();
        chk("sll_a", DataA, 32'hCAFE);
        chk("sll_b", DataB, 17);

        // back-to-back stream
        for (int i = 0; i < 8; i++) begin
            set_instr(6'h00, 6'h21, 0, 0, 5'(i + 1), 5'(i + 2), 5'(i + 3),
                      32'h100 + 32'(i), 32'h200 + 32'(i));
            step();
            chk("stream_v", out_valid, 1);
            chk("stream_a", DataA, 32'h100 + 32'(i));
        end

        // random traffic
        for (int i = 0; i < 600; i++) begin
            set_instr(pick_op(), pick_fn(), 5'($urandom), 16'($urandom),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), $urandom, $urandom);
            in_valid   = ($urandom_range(0, 9) < 8);
            out_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 19) == 0);
            fwd_m_we   = $urandom_range(0, 1);
            fwd_m_idx  = 5'($urandom_range(0, 7));
            fwd_m_data = $urandom;
            fwd_w_we   = $urandom_range(0, 1);
            fwd_w_idx  = 5'($urandom_range(0, 7));
            fwd_w_data = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
